// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-clock sample FIFO: each grant writes
// one header word tagged 2'b11 with the source index, then up to BURST data words.
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int CW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]       r_state;
  logic [NREQ-1:0]  r_grant;
  logic [CW-1:0]    r_lptr;
  logic [7:0]       r_bcnt;

  logic             w_found;
  logic [CW-1:0]    w_next_idx;
  logic [CW-1:0]    w_cand;
  logic             w_gvalid;
  logic [DSIZE-1:0] w_gdata;
  logic [DSIZE-1:0] w_hdr;
  logic             w_xfer;

  // Search order starts just after the last-granted index, wrapping modulo NREQ.
  // NOTE: every signal assigned in always_comb gets a default at the top, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = r_lptr;
    w_cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = CW'((int'(r_lptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gvalid = w_gvalid | (r_grant[i] & req_valid[i]);
      if (r_grant[i]) w_gdata = req_data[i*DSIZE +: DSIZE];
    end
  end

  // Header layout tolerates DSIZE == CW+2, where no zero padding exists.
  always_comb begin
    w_hdr                = '0;
    w_hdr[DSIZE-1 -: 2]  = 2'b11;
    w_hdr[CW-1:0]        = r_lptr;
  end

  assign w_xfer = (r_state == S_DATA) && w_gvalid && !fifo_wfull;

  always_comb begin
    fifo_winc  = 1'b0;
    fifo_wdata = '0;
    req_ready  = '0;
    case (r_state)
      S_HDR: begin
        fifo_winc  = 1'b1;
        fifo_wdata = w_hdr;
      end
      S_DATA: begin
        fifo_winc  = w_gvalid;
        fifo_wdata = w_gdata;
        req_ready  = r_grant & {NREQ{!fifo_wfull}};
      end
      default: ;
    endcase
  end

  assign grant = r_grant;
  assign busy  = (r_state != S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_lptr  <= CW'(NREQ - 1);
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= NREQ'(1) << w_next_idx;
            r_lptr  <= w_next_idx;
            r_bcnt  <= '0;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (!fifo_wfull) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_bcnt <= r_bcnt + 8'd1;
            if (r_bcnt == 8'(BURST - 1)) begin
              r_state <= S_IDLE;
              r_grant <= '0;
            end
          end else if (!w_gvalid && r_bcnt != 8'd0) begin
            // Source drained before filling the burst.
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-source word queues drive the requests, and the
// FIFO write stream is scored against a burst-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
    .grant(grant), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [7:0] sq [NREQ][0:63];
  int         hd [NREQ];
  int         tl [NREQ];

  logic [7:0] exp_w[$];
  logic [7:0] obs_w[$];
  int         exp_t[$];
  int         obs_t[$];

  logic       busy_h [512];
  logic       winc_h [512];
  logic [3:0] rdy_h  [512];
  logic [255:0] full_map;
  int         full_pct;

  task automatic push_src(input int s, input logic [7:0] w);
    sq[s][tl[s]] = w;
    tl[s]++;
  endtask

  task automatic push_rand(input int s, input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      if (w[7:6] == 2'b11) w[7] = 1'b0;
      push_src(s, w);
    end
  endtask

  task automatic drive_inputs();
    for (int s = 0; s < NREQ; s++) begin
      req_valid[s] = (hd[s] < tl[s]);
      req_data[s*DSIZE +: DSIZE] = (hd[s] < tl[s]) ? sq[s][hd[s]] : 8'h00;
    end
    fifo_wfull = (cyc < 256 && full_map[cyc]) || (int'($urandom_range(99)) < full_pct);
  endtask

  // One clock: sample away from the edge, record writes and pops, then drive next inputs.
  task automatic cycle();
    logic [3:0] pop;
    @(negedge wclk);
    pop = req_ready & req_valid;
    if (cyc < 512) begin
      busy_h[cyc] = busy;
      winc_h[cyc] = fifo_winc;
      rdy_h[cyc]  = req_ready;
    end
    total++;
    if ((req_ready & ~grant) != 0 || (fifo_wfull && req_ready != 0)) begin
      bad++;
      $display("FAIL ready_mask cyc=%0d: ready=%b grant=%b wfull=%b", cyc, req_ready, grant, fifo_wfull);
    end
    total++;
    if ($countones(grant) > 1 || busy !== (grant != 0)) begin
      bad++;
      $display("FAIL grant_busy cyc=%0d: grant=%b busy=%b", cyc, grant, busy);
    end
    if (pop != 0) begin
      for (int s = 0; s < NREQ; s++) begin
        if (pop[s]) begin
          total++;
          if (!fifo_winc || $countones(pop) != 1 || fifo_wdata !== sq[s][hd[s]]) begin
            bad++;
            $display("FAIL consume cyc=%0d src=%0d: winc=%b wdata=%h, want winc=1 wdata=%h",
                     cyc, s, fifo_winc, fifo_wdata, sq[s][hd[s]]);
          end
          hd[s]++;
        end
      end
    end
    if (fifo_winc && !fifo_wfull) begin
      obs_w.push_back(fifo_wdata);
      obs_t.push_back(cyc);
    end
    @(posedge wclk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  // Reference: grant the next non-empty source after the last one, take up to BURST words.
  task automatic build_exp(input int lp);
    int rem[NREQ];
    int ptr[NREQ];
    int cur;
    int nxt;
    cur = lp;
    exp_w.delete();
    for (int s = 0; s < NREQ; s++) begin
      rem[s] = tl[s] - hd[s];
      ptr[s] = hd[s];
    end
    forever begin
      nxt = -1;
      for (int k = 1; k <= NREQ; k++)
        if (nxt < 0 && rem[(cur + k) % NREQ] > 0) nxt = (cur + k) % NREQ;
      if (nxt < 0) break;
      exp_w.push_back(8'hC0 | 8'(nxt));
      for (int n = 0; n < BURST && rem[nxt] > 0; n++) begin
        exp_w.push_back(sq[nxt][ptr[nxt]]);
        ptr[nxt]++;
        rem[nxt]--;
      end
      cur = nxt;
    end
  endtask

  task automatic score(input string tag);
    total++;
    if (obs_w.size() != exp_w.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d words, want %0d", tag, obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      total++;
      if (obs_w[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL %s_word[%0d]: got %h, want %h", tag, i, obs_w[i], exp_w[i]);
      end
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      total++;
      if (obs_t[i] != exp_t[i]) begin
        bad++;
        $display("FAIL %s_time[%0d]: got cycle %0d, want %0d", tag, i, obs_t[i], exp_t[i]);
      end
    end
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && (busy || hd[0] < tl[0] || hd[1] < tl[1] || hd[2] < tl[2] || hd[3] < tl[3])) begin
      cycle();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want drained", tag, budget);
    end
    repeat (2) cycle();
  endtask

  task automatic reset_dut();
    for (int s = 0; s < NREQ; s++) begin
      hd[s] = 0;
      tl[s] = 0;
    end
    full_map = '0;
    full_pct = 0;
    exp_t.delete();
    obs_w.delete();
    obs_t.delete();
    cyc = 0;
    drive_inputs();
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (grant !== 4'b0 || busy !== 1'b0 || fifo_winc !== 1'b0 || req_ready !== 4'b0 || fifo_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: grant=%b busy=%b winc=%b ready=%b wdata=%h, want all zero",
               grant, busy, fifo_winc, req_ready, fifo_wdata);
    end
  endtask

  task automatic test_single();
    reset_dut();
    for (int i = 1; i <= 6; i++) push_src(2, 8'(i));
    build_exp(NREQ - 1);
    exp_t = '{1, 2, 3, 4, 5, 7, 8, 9};
    drive_inputs();
    run_until_drained("single", 100);
    score("single");
    total++;
    if (busy_h[6] !== 1'b0 || busy_h[10] !== 1'b1 || busy_h[11] !== 1'b0) begin
      bad++;
      $display("FAIL single_busy: busy@6,10,11=%b%b%b, want 010", busy_h[6], busy_h[10], busy_h[11]);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    push_rand(0, 12);
    push_rand(1, 12);
    push_rand(3, 12);
    build_exp(NREQ - 1);
    for (int b = 0; b < 9; b++)
      for (int j = 1; j <= BURST + 1; j++) exp_t.push_back(b * (BURST + 2) + j);
    drive_inputs();
    run_until_drained("round_robin", 200);
    score("round_robin");
  endtask

  task automatic test_backpressure();
    reset_dut();
    push_rand(1, 6);
    full_map[8:4] = 5'b11111;
    build_exp(NREQ - 1);
    exp_t = '{1, 2, 3, 9, 10, 12, 13, 14};
    drive_inputs();
    run_until_drained("backpressure", 100);
    score("backpressure");
    for (int c = 4; c <= 8; c++) begin
      total++;
      if (rdy_h[c] !== 4'b0 || winc_h[c] !== 1'b1) begin
        bad++;
        $display("FAIL backpressure_stall cyc=%0d: ready=%b winc=%b, want ready=0000 winc=1", c, rdy_h[c], winc_h[c]);
      end
    end
  endtask

  task automatic test_full_hdr();
    reset_dut();
    push_rand(3, 3);
    full_map[3:1] = 3'b111;
    build_exp(NREQ - 1);
    exp_t = '{4, 5, 6, 7};
    drive_inputs();
    run_until_drained("full_hdr", 100);
    score("full_hdr");
  endtask

  task automatic test_short();
    reset_dut();
    push_rand(1, 2);
    push_rand(3, 3);
    build_exp(NREQ - 1);
    exp_t = '{1, 2, 3, 6, 7, 8, 9};
    drive_inputs();
    run_until_drained("short", 100);
    score("short");
    total++;
    if (busy_h[4] !== 1'b1 || busy_h[5] !== 1'b0) begin
      bad++;
      $display("FAIL short_busy: busy@4,5=%b%b, want 10", busy_h[4], busy_h[5]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reset_dut();
    push_rand(2, 8);
    drive_inputs();
    n = 0;
    while (n < 50 && obs_w.size() < 3) begin
      cycle();
      n++;
    end
    total++;
    if (obs_w.size() < 3) begin
      bad++;
      $display("FAIL reset_mid_start: got %0d words, want 3", obs_w.size());
    end
    wrst_n = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0 || busy !== 1'b0 || fifo_winc !== 1'b0 || req_ready !== 4'b0 || fifo_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_outputs: grant=%b busy=%b winc=%b ready=%b wdata=%h, want all zero",
               grant, busy, fifo_winc, req_ready, fifo_wdata);
    end
    push_rand(0, 5);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    obs_w.delete();
    obs_t.delete();
    exp_t = '{1};
    cyc = 0;
    build_exp(NREQ - 1);
    drive_inputs();
    run_until_drained("reset_mid", 200);
    score("reset_mid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      for (int s = 0; s < NREQ; s++) push_rand(s, int'($urandom_range(12)));
      full_pct = 30;
      build_exp(NREQ - 1);
      drive_inputs();
      run_until_drained("random", 2000);
      score("random");
    end
  endtask

  initial begin
    req_valid  = '0;
    req_data   = '0;
    fifo_wfull = 1'b0;
    wrst_n     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_hdr();
    test_short();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
